// File: rtl/axi_wr_slave_pkg.sv
// axi_wr_slave_pkg
//   Shared DDR2 definitions for the AXI write slave: address/data geometry,
//   write-path FSM state encoding, BRESP codes and the wlast consistency rule.
package axi_wr_slave_pkg;

  localparam int unsigned ROW_BITS = 14;
  localparam int unsigned COL_BITS = 10;
  localparam int unsigned BA_BITS  = 3;
  localparam int unsigned DQ_BITS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // wlast must mark exactly the beat whose index equals the burst length.
  function automatic logic wlast_mismatch(input logic       last,
                                          input logic [8:0] in_cnt,
                                          input logic [7:0] len);
    logic w_is_final;
    w_is_final     = (in_cnt == {1'b0, len});
    wlast_mismatch = (last != w_is_final);
  endfunction

endpackage

// File: rtl/axi_wr_slave_fifo.sv
// sync_fifo
//   First-word-fall-through synchronous FIFO for the W beat buffer.
//   Ports:
//     clk, rstn       clock, asynchronous active-low reset (pointers only)
//     i_push, i_data  write side; ignored while full
//     i_pop           read side; ignored while empty
//     o_data          head of queue, forced to zero while empty
//     o_full, o_empty status flags
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]           r_wptr;
  logic [PW:0]           r_rptr;
  logic                  w_push;
  logic                  w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/axi_wr_slave.sv
// axi_wr_slave
//   AXI write-channel front-end of the DDR2 controller. Accepts one AW burst,
//   buffers its W beats, issues one command to the DDR2 core, streams the
//   buffered beats to it and returns B once the core reports completion.
//   Ports:
//     clk, rstn                     clock, asynchronous active-low reset
//     awvalid/awready/awaddr/awlen  AXI write address channel
//     wvalid/wready/wlast/wdata     AXI write data channel
//     bvalid/bready/bresp           AXI write response channel
//     cmd_valid/cmd_ready/cmd_addr/cmd_len  write command to the core
//     wr_valid/wr_ready/wr_data     data beats to the core
//     wr_done                       core pulse: burst committed
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS,
  parameter int unsigned DATA_WIDTH = DQ_BITS * 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done
);

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic                  r_active;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [8:0]            r_in_cnt;
  logic [8:0]            r_out_cnt;
  logic                  r_err;
  logic                  r_done_seen;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_aw_hs;
  logic                  w_push;
  logic                  w_pop;
  logic [8:0]            w_out_cnt_nxt;
  logic                  w_all_out;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (wdata),
    .i_pop   (w_pop),
    .o_data  (wr_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_aw_hs       = awvalid && awready;
  assign w_push        = wvalid && wready;
  assign w_pop         = wr_valid && wr_ready;
  assign w_out_cnt_nxt = r_out_cnt + {8'd0, w_pop};
  // Counting the pop of this cycle lets a done pulse coincident with the
  // final pop retire the burst on the same edge.
  assign w_all_out     = (w_out_cnt_nxt == ({1'b0, r_len} + 9'd1));
  assign cmd_addr      = r_addr;
  assign cmd_len       = r_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_aw_hs) w_state_nxt = ST_CMD;
      ST_CMD:  if (cmd_ready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_all_out && (r_done_seen || wr_done)) w_state_nxt = ST_RESP;
      ST_RESP: if (bready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    awready   = 1'b0;
    wready    = 1'b0;
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    bvalid    = 1'b0;
    bresp     = BRESP_OKAY;
    unique case (r_state)
      ST_IDLE: awready = r_active;
      ST_CMD: begin
        cmd_valid = 1'b1;
        wready    = !w_full && (r_in_cnt <= {1'b0, r_len});
      end
      ST_DATA: begin
        wready   = !w_full && (r_in_cnt <= {1'b0, r_len});
        wr_valid = !w_empty;
      end
      ST_RESP: begin
        bvalid = 1'b1;
        bresp  = r_err ? BRESP_SLVERR : BRESP_OKAY;
      end
      default: ;
    endcase
  end

  // r_active keeps awready low through reset and the first cycle after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active    <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_err       <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_aw_hs) begin
        r_addr      <= awaddr;
        r_len       <= awlen;
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
        r_err       <= 1'b0;
        r_done_seen <= 1'b0;
      end else begin
        if (w_push) begin
          r_in_cnt <= r_in_cnt + 9'd1;
          if (wlast_mismatch(wlast, r_in_cnt, r_len)) r_err <= 1'b1;
        end
        if (w_pop) r_out_cnt <= w_out_cnt_nxt;
        if (wr_done && (r_state != ST_IDLE)) r_done_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
module tb_axi_wr_slave;
  import axi_wr_slave_pkg::*;

  localparam int AW = ROW_BITS + COL_BITS + BA_BITS;
  localparam int DW = DQ_BITS * 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0, wready, wlast = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic          cmd_valid, cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid, wr_ready = 1'b0;
  logic [DW-1:0] wr_data;
  logic          wr_done = 1'b0;

  axi_wr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: beats the master handed over, beats the core saw.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  bit            seq_data = 1'b0;
  int            acc_cnt, acc_at_cmd, last_pop_cyc, b_cyc;
  logic [AW-1:0] obs_addr;
  logic [7:0]    obs_len;
  logic [1:0]    obs_bresp;
  bit            cmd_stable, wr_early, b_stable;
  logic          obs_aw_after;

  // A burst is OKAY exactly when wlast marks its final beat and nothing else.
  function automatic logic [1:0] model_bresp(input int len, input int last_at);
    return (last_at == len) ? 2'b00 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [AW-1:0] addr, input logic [7:0] len);
    int t = 0;
    awvalid = 1'b1; awaddr = addr; awlen = len;
    @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) begin
      errors++;
      $display("FAIL aw_timeout awready=%0b required 1", awready);
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic drive_cmd(input int delay);
    int t = 0;
    cmd_ready = 1'b0; cmd_stable = 1'b1; wr_early = 1'b0;
    @(negedge clk);
    while (!cmd_valid && t < 50) begin
      if (wr_valid) wr_early = 1'b1;
      @(negedge clk); t++;
    end
    if (!cmd_valid) begin
      errors++;
      $display("FAIL cmd_timeout cmd_valid=%0b required 1", cmd_valid);
    end
    obs_addr = cmd_addr; obs_len = cmd_len;
    if (wr_valid) wr_early = 1'b1;
    for (int i = 0; i < delay; i++) begin
      tick();
      @(negedge clk);
      if (!cmd_valid || cmd_addr !== obs_addr || cmd_len !== obs_len) cmd_stable = 1'b0;
      if (wr_valid) wr_early = 1'b1;
    end
    tick();
    cmd_ready = 1'b1;
    @(negedge clk);
    if (!cmd_valid) cmd_stable = 1'b0;
    if (wr_valid) wr_early = 1'b1;
    acc_at_cmd = acc_cnt;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic drive_w(input int n, input int last_at, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap) tick();
      wvalid = 1'b1;
      wdata  = seq_data ? DW'(i) : DW'($urandom);
      wlast  = (i == last_at);
      t = 0;
      @(negedge clk);
      while (!wready && t < 3000) begin @(negedge clk); t++; end
      if (!wready) begin
        errors++;
        $display("FAIL w_timeout beat=%0d wready=%0b required 1", i, wready);
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
      exp_q.push_back(wdata);
      acc_cnt++;
      tick();
      wvalid = 1'b0; wlast = 1'b0;
    end
  endtask

  task automatic drive_core(input int n, input int ready_pct, input int hold, input int done_delay);
    int t = 0;
    int cnt = 0;
    while (cnt < n && t < 4000) begin
      tick();
      wr_ready = (t >= hold) && ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        obs_q.push_back(wr_data);
        cnt++;
        if (cnt == n) begin
          last_pop_cyc = cyc;
          if (done_delay == 0) wr_done = 1'b1;
        end
      end
      t++;
    end
    if (cnt < n) begin
      errors++;
      $display("FAIL core_timeout pops=%0d required %0d", cnt, n);
    end
    tick();
    wr_ready = 1'b0;
    if (done_delay == 0) begin
      wr_done = 1'b0;
    end else begin
      repeat (done_delay - 1) tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
    end
  endtask

  task automatic wait_b(input int bdelay);
    int t = 0;
    b_stable = 1'b1;
    @(negedge clk);
    while (!bvalid && t < 5000) begin
      if (awready) b_stable = 1'b0;
      @(negedge clk); t++;
    end
    if (!bvalid) begin
      errors++;
      $display("FAIL b_timeout bvalid=%0b required 1", bvalid);
    end
    b_cyc = cyc;
    obs_bresp = bresp;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      @(negedge clk);
      if (!bvalid || awready || bresp !== obs_bresp) b_stable = 1'b0;
    end
    tick();
    bready = 1'b1;
    @(negedge clk);
    tick();
    bready = 1'b0;
    @(negedge clk);
    obs_aw_after = awready;
    tick();
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int last_at,
                           input int cmd_delay, input int gap, input int ready_pct,
                           input int hold, input int done_delay, input int bdelay);
    exp_q.delete(); obs_q.delete(); acc_cnt = 0;
    do_aw(addr, 8'(len));
    fork
      drive_cmd(cmd_delay);
      drive_w(len + 1, last_at, gap);
      drive_core(len + 1, ready_pct, hold, done_delay);
      wait_b(bdelay);
    join
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, bresp, cmd_valid, wr_valid} !== 7'd0 ||
        cmd_addr !== '0 || cmd_len !== 8'd0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs aw=%0b w=%0b b=%0b resp=%0b cmd=%0b addr=%0h len=%0d wrv=%0b wrd=%0h required all 0",
               awready, wready, bvalid, bresp, cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (awready !== 1'b1) begin
      errors++;
      $display("FAIL reset_awready_after got %0b required 1", awready);
    end
    tick();
  endtask

  task automatic test_single_burst();
    bit bad = 1'b0;
    seq_data = 1'b1;
    run_burst(AW'('h100), 7, 7, 0, 0, 100, 0, 2, 0);
    seq_data = 1'b0;
    checks++;
    if (obs_addr !== AW'('h100) || obs_len !== 8'd7) begin
      errors++;
      $display("FAIL single_cmd addr=%0h len=%0d required 100 7", obs_addr, obs_len);
    end
    checks++;
    if (obs_q.size() != 8) bad = 1'b1;
    else foreach (obs_q[i]) if (obs_q[i] !== DW'(i)) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL single_data count=%0d first=%0h required 8 beats 0..7", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : '0);
    end
    checks++;
    if (obs_bresp !== 2'b00 || obs_aw_after !== 1'b1) begin
      errors++;
      $display("FAIL single_resp bresp=%0b awready_after=%0b required 00 1", obs_bresp, obs_aw_after);
    end
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    fork
      run_burst(AW'($urandom), 31, 31, 0, 0, 100, 40, 1, 0);
      begin
        repeat (30) tick();
        @(negedge clk);
        checks++;
        if (acc_cnt != 16 || wready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full accepted=%0d wready=%0b required 16 0", acc_cnt, wready);
        end
      end
    join
    checks++;
    if (obs_q.size() != 32 || exp_q.size() != 32) bad = 1'b1;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL bp_data got %0d beats required 32 in order", obs_q.size());
    end
    checks++;
    if (obs_bresp !== model_bresp(31, 31)) begin
      errors++;
      $display("FAIL bp_bresp got %0b required %0b", obs_bresp, model_bresp(31, 31));
    end
  endtask

  task automatic test_early_wlast();
    bit bad = 1'b0;
    run_burst(AW'($urandom), 7, 3, 0, 0, 100, 0, 2, 0);
    checks++;
    if (acc_cnt != 8 || obs_q.size() != 8) bad = 1'b1;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL early_data accepted=%0d delivered=%0d required 8 8", acc_cnt, obs_q.size());
    end
    checks++;
    if (obs_bresp !== 2'b10) begin
      errors++;
      $display("FAIL early_bresp got %0b required 10", obs_bresp);
    end
  endtask

  task automatic test_cmd_stall();
    bit bad = 1'b0;
    logic [AW-1:0] a = AW'($urandom);
    run_burst(a, 7, 7, 10, 0, 100, 0, 2, 0);
    checks++;
    if (!cmd_stable || obs_addr !== a || obs_len !== 8'd7) begin
      errors++;
      $display("FAIL stall_cmd stable=%0b addr=%0h len=%0d required 1 %0h 7", cmd_stable, obs_addr, obs_len, a);
    end
    checks++;
    if (wr_early || acc_at_cmd != 8) begin
      errors++;
      $display("FAIL stall_buffer wr_valid_early=%0b buffered=%0d required 0 8", wr_early, acc_at_cmd);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 8) bad = 1'b1;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad || obs_bresp !== 2'b00) begin
      errors++;
      $display("FAIL stall_data beats=%0d bresp=%0b required 8 00", obs_q.size(), obs_bresp);
    end
  endtask

  task automatic test_done_with_last_pop();
    run_burst(AW'($urandom), 5, 5, 0, 0, 100, 0, 0, 5);
    checks++;
    if (b_cyc != last_pop_cyc + 1) begin
      errors++;
      $display("FAIL done_same_cycle bvalid_cycle=%0d required %0d", b_cyc, last_pop_cyc + 1);
    end
    checks++;
    if (!b_stable || obs_aw_after !== 1'b1 || obs_bresp !== 2'b00) begin
      errors++;
      $display("FAIL bready_stall held=%0b awready_after=%0b bresp=%0b required 1 1 00",
               b_stable, obs_aw_after, obs_bresp);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit bad = 1'b0;
    do_aw(AW'('h55), 8'd15);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = DW'($urandom);
      tick();
    end
    wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset wr_valid=%0b required 1", wr_valid);
    end
    #1;
    rstn = 1'b0;
    #2;
    checks++;
    if ({awready, wready, bvalid, bresp, cmd_valid, wr_valid} !== 7'd0 ||
        cmd_addr !== '0 || cmd_len !== 8'd0 || wr_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs aw=%0b w=%0b cmd=%0b addr=%0h len=%0d wrv=%0b wrd=%0h required all 0",
               awready, wready, cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data);
    end
    tick();
    rstn = 1'b1;
    tick();
    run_burst(AW'($urandom), 3, 3, 1, 10, 80, 0, 1, 1);
    checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) bad = 1'b1;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad || obs_bresp !== 2'b00) begin
      errors++;
      $display("FAIL mid_fresh_burst beats=%0d bresp=%0b required 4 00", obs_q.size(), obs_bresp);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int len = (b == 7) ? 255 : int'($urandom_range(47));
      int last_at = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : len;
      logic [AW-1:0] a = AW'($urandom);
      bit bad = 1'b0;
      run_burst(a, len, last_at, int'($urandom_range(4)), int'($urandom_range(40)),
                int'($urandom_range(100, 30)), int'($urandom_range(20)),
                int'($urandom_range(3)), int'($urandom_range(3)));
      checks++;
      if (obs_addr !== a || obs_len !== 8'(len)) begin
        errors++;
        $display("FAIL rand_cmd burst=%0d addr=%0h len=%0d required %0h %0d", b, obs_addr, obs_len, a, len);
      end
      checks++;
      if (obs_q.size() != len + 1 || exp_q.size() != len + 1) bad = 1'b1;
      else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL rand_data burst=%0d beats=%0d required %0d in order", b, obs_q.size(), len + 1);
      end
      checks++;
      if (obs_bresp !== model_bresp(len, last_at) || obs_aw_after !== 1'b1) begin
        errors++;
        $display("FAIL rand_resp burst=%0d bresp=%0b awready_after=%0b required %0b 1",
                 b, obs_bresp, obs_aw_after, model_bresp(len, last_at));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_early_wlast();
    test_cmd_stall();
    test_done_with_last_pop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog cycles=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
